branch_target_pipe: RTL and testbench

//  Two-stage pipelined immediate extractor and branch-target generator for the 64-bit pipeline.

---
 rtl/branch_target_pipe_pkg.sv | 32 +++
 rtl/branch_target_pipe_if.sv | 31 +++
 rtl/branch_target_pipe_extract.sv | 28 ++
 rtl/branch_target_pipe.sv | 109 ++++++++++
 tb/tb_branch_target_pipe.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_target_pipe_pkg.sv
// Shared types and helpers for the branch-target pipeline: immediate format enum,
// field bit positions and a generic sign-extension function.
package sext_pkg;

  // Width produced by sext(); modules slice it down to their XLEN (32..64).
  localparam int SEXT_W = 64;

  typedef enum logic [1:0] {
    SEL_CB = 2'd0,
    SEL_B  = 2'd1,
    SEL_D  = 2'd2,
    SEL_I  = 2'd3
  } imm_sel_e;

  localparam int CB_MSB = 23;
  localparam int CB_LSB = 5;
  localparam int B_MSB  = 25;
  localparam int B_LSB  = 0;
  localparam int D_MSB  = 20;
  localparam int D_LSB  = 12;
  localparam int I_MSB  = 21;
  localparam int I_LSB  = 10;

  // value holds the field right-aligned; msb is the index of its sign bit.
  // The field is pushed to the top of the word, then shifted back arithmetically.
  function automatic logic [SEXT_W-1:0] sext(input logic [31:0] value, input int msb);
    logic signed [SEXT_W-1:0] aligned;
    aligned = {value, 32'd0} << (31 - msb);
    return aligned >>> (SEXT_W - 1 - msb);
  endfunction

endpackage

// File: rtl/branch_target_pipe_if.sv
// Handshake bundle for branch_target_pipe: upstream valid/ready request and
// downstream valid/ready result.
interface branch_target_pipe_if #(
    parameter int XLEN = 64
);
  import sext_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  imm_sel_e        imm_sel;

  logic            out_valid;
  logic            out_ready;
  imm_sel_e        out_sel;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] target;
  logic            out_ovf;

  modport master (
      output in_valid, instr, pc, imm_sel, out_ready,
      input  in_ready, out_valid, out_sel, imm_ext, target, out_ovf
  );

  modport slave (
      input  in_valid, instr, pc, imm_sel, out_ready,
      output in_ready, out_valid, out_sel, imm_ext, target, out_ovf
  );

endinterface

// File: rtl/branch_target_pipe_extract.sv
// Combinational immediate extractor: picks the field for the selected format and
// sign- or zero-extends it to XLEN.
module imm_field_extract
  import sext_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  imm_sel_e        imm_sel,
    output logic [XLEN-1:0] imm_ext
);

  logic [SEXT_W-1:0] wide_next;

  always_comb begin
    wide_next = '0;
    case (imm_sel)
      SEL_CB: wide_next = sext(32'(instr[CB_MSB:CB_LSB]), CB_MSB - CB_LSB);
      SEL_B:  wide_next = sext(32'(instr[B_MSB:B_LSB]), B_MSB - B_LSB);
      SEL_D:  wide_next = sext(32'(instr[D_MSB:D_LSB]), D_MSB - D_LSB);
      SEL_I:  wide_next = SEXT_W'(instr[I_MSB:I_LSB]);
      default: wide_next = '0;
    endcase
  end

  assign imm_ext = wide_next[XLEN-1:0];

endmodule

// File: rtl/branch_target_pipe.sv
// Two-stage immediate extractor and branch-target generator with valid/ready and flush.
// Define SEXT_OVF_CHK_EN to produce the unsigned address-wrap flag on out_ovf.
module branch_target_pipe
  import sext_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int BR_SHIFT = 2
) (
    input logic clk,
    input logic reset,
    input logic flush,
    branch_target_pipe_if.slave bus
);

  logic            s1_valid_reg;
  logic [XLEN-1:0] s1_imm_reg;
  logic [XLEN-1:0] s1_pc_reg;
  imm_sel_e        s1_sel_reg;

  logic            s2_valid_reg;
  logic [XLEN-1:0] s2_imm_reg;
  logic [XLEN-1:0] s2_target_reg;
  imm_sel_e        s2_sel_reg;
  logic            s2_ovf_reg;

  logic            s2_advance;
  logic            s1_advance;
  logic            accept;
  logic [XLEN-1:0] imm_s0;
  logic            is_branch;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] target_next;
  logic            ovf_next;

  imm_field_extract #(
      .XLEN(XLEN)
  ) u_extract (
      .instr  (bus.instr),
      .imm_sel(bus.imm_sel),
      .imm_ext(imm_s0)
  );

  // in_ready depends on out_ready only through s2_advance; nothing from in_valid.
  assign s2_advance   = !s2_valid_reg || bus.out_ready;
  assign s1_advance   = s1_valid_reg && s2_advance;
  assign bus.in_ready = !flush && (!s1_valid_reg || s1_advance);
  assign accept       = bus.in_valid && bus.in_ready;

  assign is_branch = (s1_sel_reg == SEL_CB) || (s1_sel_reg == SEL_B);
  assign offset    = s1_imm_reg << BR_SHIFT;

`ifdef SEXT_OVF_CHK_EN
  logic [XLEN:0] sum;

  assign sum         = {1'b0, s1_pc_reg} + {1'b0, offset};
  assign target_next = is_branch ? sum[XLEN-1:0] : s1_imm_reg;
  // Negative offset wraps below zero when there is no carry; positive wraps above on carry.
  assign ovf_next    = is_branch && (offset[XLEN-1] ? !sum[XLEN] : sum[XLEN]);
`else
  assign target_next = is_branch ? (s1_pc_reg + offset) : s1_imm_reg;
  assign ovf_next    = 1'b0;
`endif

  // Stage 1 payload is only meaningful under s1_valid_reg, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_imm_reg <= imm_s0;
      s1_pc_reg  <= bus.pc;
      s1_sel_reg <= bus.imm_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s2_imm_reg    <= '0;
      s2_target_reg <= '0;
      s2_sel_reg    <= SEL_CB;
      s2_ovf_reg    <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_advance) begin
        s2_valid_reg <= s1_valid_reg;
        // Payload only moves with a real entry so outputs stay zero until the first result.
        if (s1_valid_reg) begin
          s2_imm_reg    <= s1_imm_reg;
          s2_target_reg <= target_next;
          s2_sel_reg    <= s1_sel_reg;
          s2_ovf_reg    <= ovf_next;
        end
      end
      if (accept) begin
        s1_valid_reg <= 1'b1;
      end else if (s1_advance) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.out_sel   = s2_sel_reg;
  assign bus.imm_ext   = s2_imm_reg;
  assign bus.target    = s2_target_reg;
  assign bus.out_ovf   = s2_ovf_reg;

endmodule

// File: tb/tb_branch_target_pipe.sv
// Bench for branch_target_pipe: directed scenarios plus random traffic scored against
// an arithmetic reference model. Honours SEXT_OVF_CHK_EN for the expected out_ovf.
module tb_branch_target_pipe;
  import sext_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  branch_target_pipe_if #(.XLEN(XLEN)) bus ();

  branch_target_pipe #(
      .XLEN    (XLEN),
      .BR_SHIFT(2)
  ) dut (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .bus  (bus.slave)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        got_valid;
  logic        got_iready;
  logic [63:0] got_imm;
  logic [63:0] got_tgt;
  logic [1:0]  got_sel;
  logic        got_ovf;
  logic        hold_prev = 1'b0;
  exp_t        prev_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: field value as an integer, sign applied by subtracting 2^width.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                 input logic [1:0] sel);
    exp_t e;
    logic [63:0] f;
    logic [63:0] off;
    int w;
    logic is_signed;
    logic signed [65:0] exact;
    f = '0;
    w = 1;
    is_signed = 1'b1;
    case (sel)
      2'd0: begin f = 64'(ins[23:5]);  w = 19; end
      2'd1: begin f = 64'(ins[25:0]);  w = 26; end
      2'd2: begin f = 64'(ins[20:12]); w = 9;  end
      default: begin f = 64'(ins[21:10]); w = 12; is_signed = 1'b0; end
    endcase
    e.sel = sel;
    e.imm = (is_signed && f[w-1]) ? f - (64'd1 << w) : f;
    e.ovf = 1'b0;
    if (sel == 2'd0 || sel == 2'd1) begin
      off   = e.imm * 64'd4;
      e.tgt = pc + off;
      exact = $signed({2'b00, pc}) + $signed({off[63], off[63], off});
`ifdef SEXT_OVF_CHK_EN
      e.ovf = (exact[65:64] != 2'b00);
`endif
    end else begin
      e.tgt = e.imm;
    end
    return e;
  endfunction

  // One clock: drive at negedge, sample just after, score, let the posedge happen.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic [1:0] sel, input logic ordy, input logic fl,
                      input logic rst);
    exp_t h;
    logic acc;
    logic take;
    @(negedge clk);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc        = pc;
    bus.imm_sel   = imm_sel_e'(sel);
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rst;
    #1;
    got_valid  = bus.out_valid;
    got_iready = bus.in_ready;
    got_imm    = bus.imm_ext;
    got_tgt    = bus.target;
    got_sel    = bus.out_sel;
    got_ovf    = bus.out_ovf;
    acc  = v && got_iready;
    take = got_valid && ordy;
    if (fl && !rst) check("flush_in_ready", 64'(got_iready), 64'd0);
    if (hold_prev && !fl && !rst) begin
      check("hold_valid", 64'(got_valid), 64'd1);
      check("hold_imm", got_imm, prev_out.imm);
      check("hold_tgt", got_tgt, prev_out.tgt);
      check("hold_sel", 64'(got_sel), 64'(prev_out.sel));
    end
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (take) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'(got_valid), 64'd0);
        end else begin
          h = sb.pop_front();
          check("sel", 64'(got_sel), 64'(h.sel));
          check("imm", got_imm, h.imm);
          check("tgt", got_tgt, h.tgt);
          check("ovf", 64'(got_ovf), 64'(h.ovf));
        end
      end
      if (acc) begin
        sb.push_back(model(ins, pc, sel));
        check("occupancy_le2", 64'(sb.size() <= 2), 64'd1);
      end
    end
    hold_prev    = got_valid && !ordy && !fl && !rst;
    prev_out.imm = got_imm;
    prev_out.tgt = got_tgt;
    prev_out.sel = got_sel;
    prev_out.ovf = got_ovf;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 64'd0, 2'd0, ordy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(got_valid), 64'd0);
    check({tag, "_imm"}, got_imm, 64'd0);
    check({tag, "_tgt"}, got_tgt, 64'd0);
    check({tag, "_sel"}, 64'(got_sel), 64'd0);
    check({tag, "_ovf"}, 64'(got_ovf), 64'd0);
    check({tag, "_in_ready"}, 64'(got_iready), 64'd1);
  endtask

  initial begin
    logic [31:0] ri;
    logic [63:0] rp;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.pc = '0;
    bus.imm_sel = SEL_CB;
    bus.out_ready = 1'b0;

    step(1'b0, 32'd0, 64'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 64'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check_reset_state("rst");

    // T1: B, all-ones offset, 2-cycle latency
    step(1'b1, 32'h03FF_FFFF, 64'h1000, 2'd1, 1'b1, 1'b0, 1'b0);
    check("t1_accept", 64'(got_iready), 64'd1);
    idle(1'b1);
    check("t1_lat1", 64'(got_valid), 64'd0);
    idle(1'b1);
    check("t1_lat2", 64'(got_valid), 64'd1);
    check("t1_imm", got_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_tgt", got_tgt, 64'h0000_0000_0000_0FFC);

    // T2: CB
    step(1'b1, 32'h5400_0200, 64'h2000, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("t2_imm", got_imm, 64'h10);
    check("t2_tgt", got_tgt, 64'h2040);
    check("t2_sel", 64'(got_sel), 64'd0);
    check("t2_ovf", 64'(got_ovf), 64'd0);

    // T3: D then I back to back
    step(1'b1, 32'h001F_F000, 64'hDEAD_0000, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h003F_FC00, 64'hBEEF_0000, 2'd3, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("t3_d_imm", got_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_d_tgt", got_tgt, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1'b1);
    check("t3_i_valid", 64'(got_valid), 64'd1);
    check("t3_i_imm", got_imm, 64'hFFF);
    check("t3_i_tgt", got_tgt, 64'hFFF);

    // T4: three inputs against a stalled consumer
    step(1'b1, 32'h0000_0040, 64'h100, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0080, 64'h200, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h0000_00C0, 64'h300, 2'd1, 1'b0, 1'b0, 1'b0);
      check("t4_in_ready", 64'(got_iready), 64'd0);
      check("t4_valid", 64'(got_valid), 64'd1);
    end
    step(1'b1, 32'h0000_00C0, 64'h300, 2'd1, 1'b1, 1'b0, 1'b0);
    check("t4_release_accept", 64'(got_iready), 64'd1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("t4_drained", 64'(sb.size()), 64'd0);

    // T5: flush with two in flight, then reset mid-stream, then reset+flush together
    step(1'b1, 32'h0000_1000, 64'h400, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_2000, 64'h500, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3000, 64'h600, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("t5_flush_valid", 64'(got_valid), 64'd0);
    idle(1'b1);
    check("t5_flush_empty", 64'(got_valid), 64'd0);
    step(1'b1, 32'h0000_1000, 64'h400, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_2000, 64'h500, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3000, 64'h600, 2'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_reset_state("t5_rst");
    step(1'b1, 32'h0000_1000, 64'h400, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_2000, 64'h500, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_3000, 64'h600, 2'd0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    check_reset_state("t5_rstfl");

    // T6: address wrap in both directions
    step(1'b1, 32'h03FF_FFFF, 64'h0, 2'd1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("t6a_tgt", got_tgt, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFC, 2'd1, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("t6b_tgt", got_tgt, 64'h0);
`ifdef SEXT_OVF_CHK_EN
    check("t6b_ovf", 64'(got_ovf), 64'd1);
`else
    check("t6b_ovf", 64'(got_ovf), 64'd0);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      rp = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 32'($urandom)}
                                       : {32'($urandom), 32'($urandom)};
      step($urandom_range(0, 3) != 0, ri, rp, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 120) == 0);
    end

    for (int i = 0; i < 6; i++) idle(1'b1);
    check("final_drained", 64'(sb.size()), 64'd0);
    check("final_valid", 64'(got_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
